vppm_mean_window_ctrl: RTL and testbench

//  Sequences the VPPM receiver's mean (decision-threshold) estimation window.

---
 rtl/vppm_mean_window_ctrl.sv | 170 +++++++++++++++++
 tb/tb_vppm_mean_window_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vppm_mean_window_ctrl.sv
// VPPM receiver mean-window sequencer.
// Skips a settling prefix of ADC strobes, decimates and sums the rest of the
// window, asks the shared divider for sum/NACC and publishes the saturated
// quotient as the slicer decision threshold.
module vppm_mean_window_ctrl #(
    parameter int NBITS1  = 16,
    parameter int NBITS2  = 12,
    parameter int N       = 96,
    parameter int DEC     = 2,
    parameter int HOLDOFF = 1024,
    parameter bit AUTO    = 1'b1,
    localparam int ACCW   = NBITS1 + NBITS2 + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     sample_vld,
    input  logic signed [NBITS1-1:0] sample_in,
    output logic                     div_req,
    output logic signed [ACCW-1:0]   div_num,
    output logic        [ACCW-1:0]   div_den,
    input  logic                     div_ack,
    input  logic signed [ACCW-1:0]   div_quot,
    output logic signed [NBITS1-1:0] thr_out,
    output logic                     thr_vld,
    output logic                     busy,
    output logic        [NBITS2-1:0] win_cnt
);

    localparam int NACC = ((2 ** NBITS2) - N + DEC - 1) / DEC;
    localparam int PHW  = (DEC > 1) ? $clog2(DEC) : 1;
    localparam int HW   = $clog2(HOLDOFF + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETTLE   = 3'd1;
    localparam logic [2:0] S_ACCUM    = 3'd2;
    localparam logic [2:0] S_DIV_WAIT = 3'd3;
    localparam logic [2:0] S_PUBLISH  = 3'd4;
    localparam logic [2:0] S_HOLD     = 3'd5;

    // With no settling prefix a window opens straight into accumulation.
    localparam logic [2:0]        S_FIRST     = (N == 0) ? S_ACCUM : S_SETTLE;
    localparam logic [NBITS2-1:0] SETTLE_LAST = (N > 0) ? NBITS2'(N - 1) : '0;
    localparam logic [NBITS2-1:0] CNT_MAX     = '1;

    // Saturation bounds of the NBITS1 signed threshold, expressed at ACCW.
    localparam logic signed [ACCW-1:0] QMAX = {{(ACCW-NBITS1+1){1'b0}}, {(NBITS1-1){1'b1}}};
    localparam logic signed [ACCW-1:0] QMIN = {{(ACCW-NBITS1+1){1'b1}}, {(NBITS1-1){1'b0}}};

    logic [2:0]               state_q, state_d;
    logic signed [ACCW-1:0]   acc_q,   acc_d;
    logic [NBITS2-1:0]        cnt_q,   cnt_d;
    logic [PHW-1:0]           ph_q,    ph_d;
    logic [HW-1:0]            hold_q,  hold_d;
    logic signed [NBITS1-1:0] lat_q,   lat_d;
    logic signed [NBITS1-1:0] thr_q,   thr_d;
    logic                     vld_q,   vld_d;

    logic signed [ACCW-1:0]   samp_ext;
    logic signed [NBITS1-1:0] quot_sat;

    assign samp_ext = {{(ACCW-NBITS1){sample_in[NBITS1-1]}}, sample_in};

    // Clamp the divider quotient into the threshold range.
    always_comb begin
        quot_sat = div_quot[NBITS1-1:0];
        if (div_quot > QMAX)
            quot_sat = {1'b0, {(NBITS1-1){1'b1}}};
        else if (div_quot < QMIN)
            quot_sat = {1'b1, {(NBITS1-1){1'b0}}};
    end

    // Next-state logic; start overrides everything and reopens the window.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        hold_d  = hold_q;
        lat_d   = lat_q;
        thr_d   = thr_q;
        vld_d   = 1'b0;

        if (start) begin
            state_d = S_FIRST;
            acc_d   = '0;
            cnt_d   = '0;
            ph_d    = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                S_SETTLE: begin
                    if (sample_vld) begin
                        cnt_d = cnt_q + NBITS2'(1);
                        if (cnt_q == SETTLE_LAST)
                            state_d = S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (sample_vld) begin
                        // Phase 0 lands on index N, so the first eligible sample is summed.
                        if (ph_q == '0)
                            acc_d = acc_q + samp_ext;
                        ph_d = (ph_q == PHW'(DEC - 1)) ? '0 : ph_q + PHW'(1);
                        // The index saturates at the last strobe rather than wrapping.
                        if (cnt_q == CNT_MAX)
                            state_d = S_DIV_WAIT;
                        else
                            cnt_d = cnt_q + NBITS2'(1);
                    end
                end
                S_DIV_WAIT: begin
                    if (div_ack) begin
                        lat_d   = quot_sat;
                        state_d = S_PUBLISH;
                    end
                end
                S_PUBLISH: begin
                    thr_d   = lat_q;
                    vld_d   = 1'b1;
                    hold_d  = '0;
                    state_d = AUTO ? S_HOLD : S_IDLE;
                end
                S_HOLD: begin
                    if (hold_q == HW'(HOLDOFF - 1)) begin
                        state_d = S_FIRST;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ph_d    = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ph_q    <= '0;
            hold_q  <= '0;
            lat_q   <= '0;
            thr_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            hold_q  <= hold_d;
            lat_q   <= lat_d;
            thr_q   <= thr_d;
            vld_q   <= vld_d;
        end
    end

    assign div_req = (state_q == S_DIV_WAIT);
    assign div_num = acc_q;
    assign div_den = ACCW'(NACC);
    assign thr_out = thr_q;
    assign thr_vld = vld_q;
    assign busy    = (state_q != S_IDLE);
    assign win_cnt = cnt_q;

endmodule

// File: tb/tb_vppm_mean_window_ctrl.sv
// Directed bench for vppm_mean_window_ctrl at default parameters.
module tb_vppm_mean_window_ctrl;

    localparam int HOLDOFF = 1024;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               sample_vld = 1'b0;
    logic signed [15:0] sample_in = '0;
    logic               div_ack = 1'b0;
    logic signed [28:0] div_quot = '0;
    logic               div_req;
    logic signed [28:0] div_num;
    logic        [28:0] div_den;
    logic signed [15:0] thr_out;
    logic               thr_vld;
    logic               busy;
    logic        [11:0] win_cnt;

    int total = 0;
    int bad = 0;
    int vld_seen = 0;

    vppm_mean_window_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .sample_vld(sample_vld), .sample_in(sample_in),
        .div_req(div_req), .div_num(div_num), .div_den(div_den),
        .div_ack(div_ack), .div_quot(div_quot),
        .thr_out(thr_out), .thr_vld(thr_vld), .busy(busy), .win_cnt(win_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (thr_vld === 1'b1) vld_seen++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic strobe(input int v);
        sample_vld = 1'b1;
        sample_in  = 16'(v);
        tick(1);
        sample_vld = 1'b0;
    endtask

    // Full 4096-strobe window: settle value for indices 0..95, then even/odd offsets.
    task automatic send_window(input int sv, input int ve, input int vo);
        for (int i = 0; i < 4096; i++)
            strobe(i < 96 ? sv : ((((i - 96) % 2) == 0) ? ve : vo));
    endtask

    task automatic ack(input int q, input bit with_start);
        div_quot = 29'(q);
        div_ack  = 1'b1;
        start    = with_start;
        tick(1);
        div_ack  = 1'b0;
        start    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        total++; if (div_req !== 1'b0) begin bad++; $display("FAIL rst_div_req got=%0b want=0", div_req); end
        total++; if (thr_out !== 16'sd0) begin bad++; $display("FAIL rst_thr_out got=%0d want=0", thr_out); end
        total++; if (thr_vld !== 1'b0) begin bad++; $display("FAIL rst_thr_vld got=%0b want=0", thr_vld); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
        total++; if (win_cnt !== 12'd0) begin bad++; $display("FAIL rst_win_cnt got=%0d want=0", win_cnt); end
        rst = 1'b0;
        strobe(3);
        tick(2);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_rst busy got=%0b want=0", busy); end
    endtask

    task automatic test_basic();
        int v0;
        do_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy got=%0b want=1", busy); end
        total++; if (win_cnt !== 12'd0) begin bad++; $display("FAIL t1_cnt0 got=%0d want=0", win_cnt); end
        v0 = vld_seen;
        for (int i = 0; i < 96; i++) strobe(100);
        total++; if (win_cnt !== 12'd96) begin bad++; $display("FAIL t1_settle_cnt got=%0d want=96", win_cnt); end
        for (int i = 96; i < 4096; i++) strobe(100);
        total++; if (div_req !== 1'b1) begin bad++; $display("FAIL t1_req got=%0b want=1", div_req); end
        total++; if (div_num !== 29'sd200000) begin bad++; $display("FAIL t1_num got=%0d want=200000", div_num); end
        total++; if (div_den !== 29'd2000) begin bad++; $display("FAIL t1_den got=%0d want=2000", div_den); end
        total++; if (win_cnt !== 12'd4095) begin bad++; $display("FAIL t1_cnt_end got=%0d want=4095", win_cnt); end
        tick(5);
        total++; if (div_req !== 1'b1) begin bad++; $display("FAIL t1_req_held got=%0b want=1", div_req); end
        ack(100, 1'b0);
        total++; if (div_req !== 1'b0 || thr_vld !== 1'b0) begin bad++; $display("FAIL t1_after_ack req=%0b vld=%0b want 0/0", div_req, thr_vld); end
        tick(1);
        total++; if (thr_vld !== 1'b1) begin bad++; $display("FAIL t1_vld got=%0b want=1", thr_vld); end
        total++; if (thr_out !== 16'sd100) begin bad++; $display("FAIL t1_thr got=%0d want=100", thr_out); end
        tick(2);
        total++; if (vld_seen - v0 !== 1) begin bad++; $display("FAIL t1_vld_count got=%0d want=1", vld_seen - v0); end
    endtask

    task automatic test_decimation();
        do_start();
        send_window(30000, 50, 1000);
        total++; if (div_num !== 29'sd100000) begin bad++; $display("FAIL t2_num got=%0d want=100000", div_num); end
        ack(50, 1'b0);
        tick(1);
        total++; if (thr_out !== 16'sd50 || thr_vld !== 1'b1) begin bad++; $display("FAIL t2_thr got=%0d vld=%0b want=50/1", thr_out, thr_vld); end
    endtask

    task automatic test_auto_rearm();
        do_start();
        send_window(-300, -300, -300);
        total++; if (div_num !== -29'sd600000) begin bad++; $display("FAIL t3_num got=%0d want=-600000", div_num); end
        ack(-300, 1'b0);
        tick(1);
        total++; if (thr_out !== -16'sd300 || thr_vld !== 1'b1) begin bad++; $display("FAIL t3_thr got=%0d vld=%0b want=-300/1", thr_out, thr_vld); end
        tick(HOLDOFF - 1);
        total++; if (win_cnt !== 12'd4095) begin bad++; $display("FAIL t3_hold_early got=%0d want=4095", win_cnt); end
        tick(1);
        total++; if (win_cnt !== 12'd0 || busy !== 1'b1) begin bad++; $display("FAIL t3_rearm cnt=%0d busy=%0b want=0/1", win_cnt, busy); end
        strobe(5);
        total++; if (win_cnt !== 12'd1) begin bad++; $display("FAIL t3_new_window got=%0d want=1", win_cnt); end
    endtask

    task automatic test_restart_accum();
        do_start();
        for (int i = 0; i < 2000; i++) strobe(500);
        total++; if (win_cnt !== 12'd2000) begin bad++; $display("FAIL t4_cnt got=%0d want=2000", win_cnt); end
        do_start();
        total++; if (win_cnt !== 12'd0 || busy !== 1'b1) begin bad++; $display("FAIL t4_restart cnt=%0d busy=%0b want=0/1", win_cnt, busy); end
        send_window(7, 7, 7);
        total++; if (div_num !== 29'sd14000) begin bad++; $display("FAIL t4_num got=%0d want=14000", div_num); end
        ack(7, 1'b0);
        tick(1);
        total++; if (thr_out !== 16'sd7) begin bad++; $display("FAIL t4_thr got=%0d want=7", thr_out); end
    endtask

    task automatic test_start_on_ack();
        int v0;
        bit held;
        do_start();
        send_window(20, 20, 20);
        total++; if (div_num !== 29'sd40000) begin bad++; $display("FAIL t5_num got=%0d want=40000", div_num); end
        held = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (div_req !== 1'b1) held = 1'b0;
        end
        total++; if (held !== 1'b1) begin bad++; $display("FAIL t5_req_held got=%0b want=1", held); end
        v0 = vld_seen;
        ack(20, 1'b1);
        total++; if (div_req !== 1'b0 || win_cnt !== 12'd0 || busy !== 1'b1) begin bad++; $display("FAIL t5_restart req=%0b cnt=%0d busy=%0b want=0/0/1", div_req, win_cnt, busy); end
        tick(3);
        total++; if (thr_out !== 16'sd7) begin bad++; $display("FAIL t5_thr_kept got=%0d want=7", thr_out); end
        total++; if (vld_seen !== v0) begin bad++; $display("FAIL t5_no_vld got=%0d want=%0d", vld_seen, v0); end
    endtask

    task automatic test_saturation();
        do_start();
        send_window(1, 1, 1);
        ack(100000, 1'b0);
        tick(1);
        total++; if (thr_out !== 16'sd32767) begin bad++; $display("FAIL sat_hi got=%0d want=32767", thr_out); end
        do_start();
        send_window(-1, -1, -1);
        ack(-70000, 1'b0);
        tick(1);
        total++; if (thr_out !== -16'sd32768) begin bad++; $display("FAIL sat_lo got=%0d want=-32768", thr_out); end
    endtask

    task automatic test_rst_in_div_wait();
        int v0;
        do_start();
        send_window(9, 9, 9);
        total++; if (div_req !== 1'b1) begin bad++; $display("FAIL t6_req got=%0b want=1", div_req); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        total++; if (div_req !== 1'b0 || thr_out !== 16'sd0 || busy !== 1'b0) begin bad++; $display("FAIL t6_rst req=%0b thr=%0d busy=%0b want=0/0/0", div_req, thr_out, busy); end
        for (int i = 0; i < 10; i++) strobe(9);
        total++; if (win_cnt !== 12'd0 || busy !== 1'b0) begin bad++; $display("FAIL t6_ignore cnt=%0d busy=%0b want=0/0", win_cnt, busy); end
        v0 = vld_seen;
        ack(5, 1'b0);
        tick(2);
        total++; if (vld_seen !== v0 || thr_out !== 16'sd0) begin bad++; $display("FAIL t6_idle_ack vld=%0d thr=%0d want=%0d/0", vld_seen, thr_out, v0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_decimation();
        test_auto_rearm();
        test_restart_accum();
        test_start_on_ack();
        test_saturation();
        test_rst_in_div_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
